// File: rtl/jk_bank_driver.sv
// Command-side driver for a bank of WIDTH JK flip-flops: turns load, toggle-mask and
// count requests into registered per-bit JK commands while tracking a shadow of the bank.
module jk_bank_driver #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_mode,
    input  logic [WIDTH-1:0]     req_data,
    output logic [2*WIDTH-1:0]   jk_bus,
    output logic [WIDTH-1:0]     q_shadow,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] MODE_LOAD   = 2'd0;
    localparam logic [1:0] MODE_TOGGLE = 2'd1;
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     pred, pred_next;
    logic [WIDTH-1:0]     steps, steps_next;
    logic [WIDTH-1:0]     step_val;
    logic                 down, down_next;
    logic [2*WIDTH-1:0]   jk_next;
    logic                 ready_next, busy_next, done_next;

    // Counting only sets/resets the bits that differ, never toggles.
    function automatic logic [2*WIDTH-1:0] step_cmd(input logic [WIDTH-1:0] from,
                                                    input logic [WIDTH-1:0] to);
        logic [2*WIDTH-1:0] cmd;
        cmd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (from[i] != to[i])
                cmd[2*i +: 2] = to[i] ? 2'b10 : 2'b01;
        end
        return cmd;
    endfunction

    function automatic logic [WIDTH-1:0] apply_cmd(input logic [WIDTH-1:0] q,
                                                   input logic [2*WIDTH-1:0] cmd);
        logic [WIDTH-1:0] r;
        r = q;
        for (int i = 0; i < WIDTH; i++) begin
            case (cmd[2*i +: 2])
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                2'b11:   r[i] = ~q[i];
                default: r[i] = q[i];
            endcase
        end
        return r;
    endfunction

    always_comb begin
        state_next = state;
        pred_next  = pred;
        steps_next = steps;
        down_next  = down;
        step_val   = '0;
        jk_next    = '0;
        ready_next = 1'b0;
        busy_next  = 1'b1;
        done_next  = 1'b0;
        case (state)
            INIT: begin
                state_next = IDLE;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
            IDLE: begin
                ready_next = 1'b1;
                busy_next  = 1'b0;
                if (req_valid && req_ready) begin
                    state_next = ISSUE;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                    steps_next = '0;
                    down_next  = req_mode[0];
                    if (req_mode == MODE_LOAD) begin
                        for (int i = 0; i < WIDTH; i++)
                            jk_next[2*i +: 2] = req_data[i] ? 2'b10 : 2'b01;
                    end else if (req_mode == MODE_TOGGLE) begin
                        for (int i = 0; i < WIDTH; i++)
                            jk_next[2*i +: 2] = req_data[i] ? 2'b11 : 2'b00;
                    end else if (req_data != '0) begin
                        // jk_bus is idle here, so q_shadow is the bank value the count starts from.
                        step_val   = req_mode[0] ? (q_shadow - ONE) : (q_shadow + ONE);
                        jk_next    = step_cmd(q_shadow, step_val);
                        pred_next  = step_val;
                        steps_next = req_data - ONE;
                    end
                end
            end
            ISSUE: begin
                if (steps == '0) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    step_val   = down ? (pred - ONE) : (pred + ONE);
                    jk_next    = step_cmd(pred, step_val);
                    pred_next  = step_val;
                    steps_next = steps - ONE;
                end
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            jk_bus    <= {WIDTH{2'b01}};
            q_shadow  <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pred      <= '0;
            steps     <= '0;
            down      <= 1'b0;
        end else begin
            state     <= state_next;
            jk_bus    <= jk_next;
            q_shadow  <= apply_cmd(q_shadow, jk_bus);
            req_ready <= ready_next;
            busy      <= busy_next;
            done      <= done_next;
            pred      <= pred_next;
            steps     <= steps_next;
            down      <= down_next;
        end
    end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Command-side driver for a bank of WIDTH JK flip-flops. The bank uses per-bit 2-bit JK inputs and positive-edge clocking, with no reset of its own.
- The block accepts load, toggle-mask and count requests over a valid/ready handshake. It converts each request into a registered sequence of per-bit JK commands.
- It keeps a shadow copy of the bank state, which is the only place the bank value is known.
- It sits between control logic and the JK register bank, and both run on the same clk.

Parameters:
- WIDTH, 4, number of JK flip-flops driven; also the width of req_data and q_shadow.

Ports:
- clk  input  1  rising-edge clock, shared with the JK bank.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present; must stay stable until accepted.
- req_ready  output  1  block can accept a request this cycle.
- req_mode  input  2  0 LOAD, 1 TOGGLE_MASK, 2 COUNT_UP, 3 COUNT_DOWN.
- req_data  input  WIDTH  LOAD: target value; TOGGLE_MASK: bits to toggle; COUNT_*: number of steps N (0 allowed).
- jk_bus  output  2*WIDTH  bank command; bit i uses jk_bus[2i+1]=J and jk_bus[2i]=K.
- q_shadow  output  WIDTH  value the bank holds after the most recent clk edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when the bank has taken the final command of a request.

Behaviour:
- JK command encoding per bit: 00 hold, 01 reset (q=0), 10 set (q=1), 11 toggle.
- All outputs are registered.
- Reset (asynchronous, takes effect immediately):
  - state=INIT, jk_bus = all bits 01 (the bank clears on every clk while rst is high).
  - q_shadow=0, req_ready=0, busy=1, done=0.
  - Any pending request or count in progress is discarded.
- States:
  - INIT → IDLE on the first edge after rst deasserts. That edge sets jk_bus=all 00 and req_ready=1.
  - IDLE: req_ready=1, busy=0, jk_bus=all 00.
  - A request is accepted on edge t when req_valid&&req_ready. On that edge, req_ready goes to 0 and state moves to ISSUE.
  - ISSUE: commands are placed on jk_bus on edges t .. t+M-1, with M=max(N,1) for COUNT and M=1 otherwise.
  - On edge t+M: jk_bus=all 00, done=1 for one cycle, state=IDLE, req_ready=1. Earliest next acceptance is edge t+M+1.
- Command on edge t by mode:
  - LOAD: bit i gets 10 if req_data[i]=1, otherwise 01.
  - TOGGLE_MASK: bit i gets 11 if req_data[i]=1, otherwise 00.
  - COUNT with N=0: all 00; done still pulses on edge t+1.
- COUNT commands:
  - An internal predicted value v is the bank value after the command currently being issued.
  - Each step computes next = v±1 mod 2^WIDTH.
  - Bits that change get 10 (0→1) or 01 (1→0); unchanged bits get 00. Toggle is not used for counting.
  - An internal step counter loads N-1 at acceptance, decrements per issued command, and the last command is issued when it reaches 0.
  - Wrap: up from all-ones → 0 (every bit reset); down from 0 → all-ones (every bit set).
- q_shadow timing:
  - q_shadow updates on the same edge on which the bank applies a command (one edge after the command is registered).
  - It therefore equals bank q after every edge.
  - When done is high, q_shadow holds the final value.
- Handshake: req_valid while busy is ignored, and nothing is queued. Changing req_* while req_ready=0 has no effect.
- Illegal states fall back to IDLE with jk_bus=all 00.

Test Plan:
- Reset: rst high for 3 clks, then low → jk_bus=8'h55 during reset; after release INIT then IDLE, req_ready=1, q_shadow=0, bank q=0.
- LOAD 4'b1010 accepted at edge t → jk_bus=8'b10_01_10_01 after t. Edge t+1: jk_bus=0, q_shadow=4'hA, done pulses once.
- TOGGLE_MASK 4'b0110 from 4'hA → jk_bus=8'b00_11_11_00, then q_shadow=4'hC. Repeating the same mask returns q_shadow to 4'hA.
- COUNT_UP N=3 from 4'hE → q_shadow 4'hF, 4'h0, 4'h1 on successive edges. Wrap command is 8'b01_01_01_01. done on edge t+3; busy high for 3 cycles.
- COUNT_DOWN N=2 from 4'h0 → q_shadow 4'hF then 4'hE. COUNT_UP N=0 → no bank change, done on edge t+1.
- rst asserted mid COUNT_UP N=10 → jk_bus=all 01 immediately, q_shadow=0, done never pulses. After release, a new LOAD 4'h5 completes normally. A req_valid held high during busy is accepted only once.
